// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot sequencer.
// Holds the FSM state encoding and default ROM size.
package boot_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_WRITE,
        S_EXEC,
        S_HPS
    } state_t;

    localparam logic [15:0] BOOT_ROM_END_DEFAULT = 16'd275;
    localparam logic [7:0]  HPS_INDEX            = 8'd0;

endpackage

// File: rtl/boot_sequencer_if.sv
// Core download bus between the boot sequencer and the core.
// master drives the write strobe/address/data, slave back-pressures.
interface boot_sequencer_if;

    logic        dn_go;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_busy;

    modport master (
        output dn_go,
        output dn_wr,
        output dn_addr,
        output dn_data,
        input  dn_busy
    );

    modport slave (
        input  dn_go,
        input  dn_wr,
        input  dn_addr,
        input  dn_data,
        output dn_busy
    );

endinterface

// File: rtl/boot_sequencer.sv
// Copies the boot ROM into the core after reset, then hands over
// to HPS index-0 downloads and re-runs the copy when they end.
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter logic [15:0] BOOT_ROM_END = BOOT_ROM_END_DEFAULT,
    parameter logic [15:0] EXEC_ADDR    = 16'h0000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             model,
    output logic [15:0]      rom_addr,
    output logic             rom_model,
    input  logic [7:0]       rom_data,
    input  logic             ioctl_download,
    input  logic [7:0]       ioctl_index,
    input  logic             ioctl_wr,
    input  logic [15:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    output logic             ioctl_wait,
    boot_sequencer_if.master dn,
    output logic             execute_enable,
    output logic [15:0]      execute_addr,
    output logic             busy
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        hps_wr_q;
    logic        model_q;
    logic        dl0;
    logic        last_byte;

    assign dl0       = ioctl_download && (ioctl_index == HPS_INDEX);
    assign last_byte = (cnt_q == BOOT_ROM_END);

    // State register; reset parks on FETCH so release starts a copy.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state: 3-cycle copy loop, one-shot exec, HPS passthrough.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (dl0) state_d = S_HPS;
            S_FETCH:   state_d = S_ROMWAIT;
            S_ROMWAIT: state_d = S_WRITE;
            S_WRITE: begin
                if (!dn.dn_busy) state_d = last_byte ? S_EXEC : S_FETCH;
            end
            S_EXEC:    state_d = S_IDLE;
            S_HPS:     if (!ioctl_download) state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: byte counter, write address/data, HPS strobe, model latch.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            hps_wr_q <= 1'b0;
            model_q  <= model;
        end else begin
            hps_wr_q <= 1'b0;
            unique case (state_q)
                S_FETCH:   addr_q <= cnt_q;
                S_ROMWAIT: data_q <= rom_data;
                S_WRITE: begin
                    if (!dn.dn_busy && !last_byte) cnt_q <= cnt_q + 16'd1;
                end
                S_HPS: begin
                    addr_q   <= ioctl_addr;
                    data_q   <= ioctl_dout;
                    hps_wr_q <= ioctl_wr && !dn.dn_busy;
                    if (!ioctl_download) begin
                        cnt_q   <= '0;
                        model_q <= model;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: decoded from state, forced to zero while in reset.
    always_comb begin
        rom_addr       = '0;
        rom_model      = model;
        ioctl_wait     = 1'b0;
        dn.dn_go       = 1'b0;
        dn.dn_wr       = 1'b0;
        dn.dn_addr     = '0;
        dn.dn_data     = '0;
        execute_enable = 1'b0;
        execute_addr   = '0;
        busy           = 1'b0;
        if (reset_n) begin
            rom_addr     = cnt_q;
            rom_model    = model_q;
            dn.dn_addr   = addr_q;
            dn.dn_data   = data_q;
            dn.dn_wr     = hps_wr_q;
            execute_addr = EXEC_ADDR;
            busy         = (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: ;
                S_FETCH, S_ROMWAIT: begin
                    dn.dn_go   = 1'b1;
                    ioctl_wait = dl0;
                end
                S_WRITE: begin
                    dn.dn_go   = 1'b1;
                    dn.dn_wr   = !dn.dn_busy;
                    ioctl_wait = dl0;
                end
                S_EXEC: begin
                    execute_enable = 1'b1;
                    ioctl_wait     = dl0;
                end
                S_HPS: begin
                    dn.dn_go   = 1'b1;
                    ioctl_wait = dn.dn_busy;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter BOOT_ROM_END, default 16'd275, address of the last boot-ROM byte; copy length is BOOT_ROM_END+1 bytes.
REQ-002 Parameter EXEC_ADDR, default 16'h0000, value driven on execute_addr.
REQ-003 clk_sys  in  1  system clock; every flop is in this domain.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 model  in  1  machine model select, sampled at copy start.
REQ-006 rom_addr  out  16  boot-ROM read address.
REQ-007 rom_model  out  1  latched model passed to the boot ROM.
REQ-008 rom_data  in  8  boot-ROM data, valid one cycle after rom_addr.
REQ-009 ioctl_download  in  1  HPS download active.
REQ-010 ioctl_index  in  8  HPS download index; only index 0 is serviced.
REQ-011 ioctl_wr  in  1  HPS byte strobe.
REQ-012 ioctl_addr  in  16  HPS byte address.
REQ-013 ioctl_dout  in  8  HPS byte data.
REQ-014 ioctl_wait  out  1  stall request to HPS.
REQ-015 dn_go  out  1  core download window is open.
REQ-016 dn_wr  out  1  single-cycle write strobe to the core.
REQ-017 dn_addr  out  16  core write address.
REQ-018 dn_data  out  8  core write data.
REQ-019 dn_busy  in  1  core cannot accept a write this cycle.
REQ-020 execute_enable  out  1  single-cycle start pulse.
REQ-021 execute_addr  out  16  constant EXEC_ADDR.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 States: IDLE, FETCH, ROMWAIT, WRITE, EXEC, HPS.
REQ-024 Flow: FETCH -> ROMWAIT -> WRITE, three cycles per byte with dn_busy low.
- FETCH drives rom_addr = byte counter.
- ROMWAIT captures rom_data into the data register at the end of the cycle.
REQ-025 In WRITE, dn_wr shall be 1 only when dn_busy=0.
- dn_addr and dn_data are registered values.
- While dn_busy=1, the FSM holds in WRITE with dn_wr=0.
REQ-026 After an accepted write:
- counter == BOOT_ROM_END -> EXEC.
- otherwise, counter+1 -> FETCH.
- The counter shall never wrap.
REQ-027 EXEC asserts execute_enable for exactly one cycle, then the FSM goes to IDLE.
REQ-028 dn_go shall be 1 in FETCH, ROMWAIT, WRITE and HPS, and 0 in IDLE and EXEC.
REQ-029 rom_model shall latch model on entry to FETCH for byte 0 only; later changes to model have no effect until the next copy.
REQ-030 IDLE with ioctl_download=1 and ioctl_index=0 -> HPS.
REQ-031 In HPS, each HPS byte is forwarded with one cycle of latency:
- dn_wr = registered (ioctl_wr and not dn_busy).
- dn_addr and dn_data are the registered ioctl_addr and ioctl_dout.
REQ-032 In HPS, ioctl_wait = dn_busy.
REQ-033 In FETCH, ROMWAIT, WRITE and EXEC, ioctl_wait = 1 whenever ioctl_download=1 and ioctl_index=0.
REQ-034 Outside HPS, an index-0 download shall not start until the boot copy has finished.
REQ-035 HPS exit: on the first cycle ioctl_download=0 -> FETCH with counter 0, which re-runs the boot copy.
REQ-036 Downloads with ioctl_index != 0 are ignored: ioctl_wait=0, no state change.

Reset
REQ-037 While reset_n=0, all outputs shall be 0 and the counter 0; rom_model takes the value of model.
REQ-038 The first cycle with reset_n=1 shall be FETCH for byte 0, so the copy always starts on reset release.
REQ-039 reset_n=0 mid-copy or mid-HPS shall abort within the same clock edge; no partial dn_wr follows.

Structure
REQ-040 A shared package boot_seq_pkg shall hold:
- the state enum;
- BOOT_ROM_END_DEFAULT = 16'd275.
REQ-041 The module shall be a single module with no sub-modules; the boot ROM stays external.

Verification
REQ-042 Copy, no stall: reset_n 0->1 with rom_data = address[7:0].
- Required: 276 dn_wr pulses.
- The first pulse is 2 cycles after release; then one pulse every 3 cycles.
- The last pulse carries dn_addr=275, dn_data=8'h13.
- execute_enable pulses once, the cycle after the last write.
REQ-043 Stall: hold dn_busy=1 for 5 cycles while in WRITE at byte 10.
- Required: no dn_wr during the stall.
- Then exactly one dn_wr with dn_addr=10.
- Total write count stays 276.
REQ-044 Contention: assert ioctl_download with ioctl_index=0 at byte 100.
- Required: ioctl_wait=1 until the copy completes.
- execute_enable pulses, then the FSM enters HPS and ioctl_wait follows dn_busy.
- A write with ioctl_addr=16'h0042, ioctl_dout=8'hA5 appears one cycle later as dn_addr=16'h0042, dn_data=8'hA5.
REQ-045 HPS exit: drop ioctl_download.
- Required: the next cycle is FETCH with rom_addr=0.
- A full 276-byte copy follows, then one execute_enable.
REQ-046 Reset mid-copy: reset_n=0 for 1 cycle at byte 200.
- Required: all outputs 0 during reset.
- The copy restarts at dn_addr=0 with no write above byte 200 before the restart.
REQ-047 Ignored index: ioctl_download=1 with ioctl_index=1 while in IDLE.
- Required: no state change; ioctl_wait=0; dn_go=0.
